// File: rtl/port_input_conditioner.sv
// port_input_conditioner
//
// Conditions raw, asynchronous board pins (buttons, switches, joystick
// lines) before they reach the RIOT port inputs. Every bit is brought into
// the CLK domain through a two-flop synchroniser and then debounced by its
// own counter. A new level is accepted only after DB_CYCLES consecutive
// CE-qualified samples disagree with the current stable level; any sample
// that agrees again clears the count, so a bounce restarts the full wait.
//
// Ports:
//   CLK     in   1      system clock, all state changes on posedge
//   RES     in   1      synchronous active-high reset
//   CE      in   1      sample enable (prescaler tick)
//   Pin     in   WIDTH  raw asynchronous pin levels
//   Pout    out  WIDTH  debounced stable levels (to PAin/PBin)
//   Rise    out  WIDTH  one-cycle pulse on an accepted 0->1 transition
//   Fall    out  WIDTH  one-cycle pulse on an accepted 1->0 transition
//   Changed out  1      OR of Rise|Fall, same cycle as them
//
// All outputs come straight from flops; there is no combinational path
// from Pin or CE to any output.
module port_input_conditioner #(
  parameter int unsigned           WIDTH     = 8,
  parameter int unsigned           DB_CYCLES = 1000,
  parameter int unsigned           CNT_W     = 10,
  parameter logic [WIDTH-1:0]      RST_VAL   = 8'hFF
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             CE,
  input  logic [WIDTH-1:0] Pin,
  output logic [WIDTH-1:0] Pout,
  output logic [WIDTH-1:0] Rise,
  output logic [WIDTH-1:0] Fall,
  output logic             Changed
);

  // Terminal count: the DB_CYCLES-th mismatch sample sees this value.
  // DB_CYCLES may be as large as 2^CNT_W, so DB_CYCLES-1 always fits.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Next-state: synchroniser shift plus the per-bit debounce rule.
  always_comb begin
    sync1_d = Pin;
    sync2_d = sync1_q;
    pout_d  = pout_q;
    rise_d  = {WIDTH{1'b0}};
    fall_d  = {WIDTH{1'b0}};
    cnt_d   = cnt_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync2_q[i] != pout_q[i]) begin
        if (CE) begin
          if (cnt_q[i] == CNT_MAX) begin
            // Enough qualifying samples: accept the new level and pulse.
            pout_d[i] = sync2_q[i];
            cnt_d[i]  = {CNT_W{1'b0}};
            if (sync2_q[i]) begin
              rise_d[i] = 1'b1;
            end else begin
              fall_d[i] = 1'b1;
            end
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end else begin
        // Input agrees with the stable level: a glitch or bounce ended,
        // so drop any partial count whether or not CE is high.
        cnt_d[i] = {CNT_W{1'b0}};
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  // State register with synchronous reset that overrides everything.
  always_ff @(posedge CLK) begin
    if (RES) begin
      sync1_q   <= RST_VAL;
      sync2_q   <= RST_VAL;
      pout_q    <= RST_VAL;
      rise_q    <= {WIDTH{1'b0}};
      fall_q    <= {WIDTH{1'b0}};
      changed_q <= 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pout_q    <= pout_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign Pout    = pout_q;
  assign Rise    = rise_q;
  assign Fall    = fall_q;
  assign Changed = changed_q;

endmodule

// File: tb/tb_port_input_conditioner.sv
// Testbench for port_input_conditioner (DB_CYCLES=4).
// A reference model runs on every posedge and pushes the expected pulse
// event into a queue; a monitor on the negedge pops and compares whenever
// the DUT raises Changed, and also tracks the stable Pout level.
module tb_port_input_conditioner;

  localparam int         W   = 8;
  localparam int         DB  = 4;
  localparam logic [7:0] RST = 8'hFF;

  logic         clk = 1'b0;
  logic         res;
  logic         ce;
  logic [W-1:0] pin;
  logic [W-1:0] pout, rise, fall;
  logic         changed;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] f;
    logic [W-1:0] p;
  } ev_t;

  ev_t exp_q[$];

  // Model state: what the pins look like after the two sync stages, the
  // accepted level, and how many enabled samples in a row disagreed.
  logic [W-1:0] m_s1, m_s2, m_pout;
  int           m_run [W];

  port_input_conditioner #(
    .WIDTH(W), .DB_CYCLES(DB), .CNT_W(10), .RST_VAL(RST)
  ) dut (
    .CLK(clk), .RES(res), .CE(ce), .Pin(pin),
    .Pout(pout), .Rise(rise), .Fall(fall), .Changed(changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: evaluates the debounce rule once per clock edge.
  initial begin
    logic [W-1:0] r, f;
    m_s1 = RST; m_s2 = RST; m_pout = RST;
    for (int i = 0; i < W; i++) m_run[i] = 0;
    forever begin
      @(posedge clk);
      if (res === 1'b1) begin
        m_s1 = RST; m_s2 = RST; m_pout = RST;
        for (int i = 0; i < W; i++) m_run[i] = 0;
      end else begin
        r = '0; f = '0;
        for (int i = 0; i < W; i++) begin
          if (m_s2[i] == m_pout[i]) begin
            m_run[i] = 0;
          end else if (ce) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == DB) begin
              m_run[i] = 0;
              m_pout[i] = m_s2[i];
              if (m_s2[i]) r[i] = 1'b1; else f[i] = 1'b1;
            end
          end
        end
        if ((r | f) != '0) exp_q.push_back('{r: r, f: f, p: m_pout});
        m_s2 = m_s1;
        m_s1 = pin;
      end
    end
  end

  // Monitor: compares DUT outputs on the falling edge.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      check("pout_level", pout, m_pout);
      check("rise_fall_exclusive", rise & fall, '0);
      check("changed_or", {7'd0, changed}, {7'd0, |(rise | fall)});
      if (changed === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse actual rise=%h fall=%h expected none at %0t",
                   rise, fall, $time);
        end else begin
          e = exp_q.pop_front();
          check("rise", rise, e.r);
          check("fall", fall, e.f);
          check("pout_at_pulse", pout, e.p);
        end
      end else begin
        check("no_rise", rise, '0);
        check("no_fall", fall, '0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++; errors++;
          $display("FAIL missed_pulse actual none expected rise=%h fall=%h at %0t",
                   e.r, e.f, $time);
        end
      end
    end
  end

  task automatic tick(input logic [W-1:0] p, input logic c, input logic rs);
    pin = p; ce = c; res = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [W-1:0] p, input int n);
    for (int k = 0; k < n; k++) tick(p, 1'b1, 1'b0);
  endtask

  initial begin
    logic [W-1:0] p;
    pin = RST; ce = 1'b1; res = 1'b1;
    @(posedge clk); #1;
    res = 1'b0;
    #4;
    check("reset_pout", pout, 8'hFF);
    check("reset_rise", rise, 8'h00);
    check("reset_fall", fall, 8'h00);
    check("reset_changed", {7'd0, changed}, 8'h00);
    hold(8'hFF, 50);

    // Clean press on bit 0.
    hold(8'hFE, 12);
    check("press_pout", pout, 8'hFE);
    hold(8'hFF, 12);

    // Bounce on bit 3, then settle low.
    for (int k = 0; k < 4; k++) hold((k % 2 == 0) ? 8'hFF : 8'hF7, 2);
    for (int k = 0; k < 3; k++) hold((k % 2 == 0) ? 8'hFF : 8'hF7, 2);
    hold(8'hF7, 12);
    check("bounce_pout", pout, 8'hF7);

    // CE gating on bit 7: settle low, then rise with CE every 3rd cycle.
    hold(8'h7F, 12);
    for (int k = 0; k < 30; k++) tick(8'hFF, (k % 3 == 0), 1'b0);
    check("ce_gated_pout", pout, 8'hFF);

    // Simultaneous fall on the upper nibble.
    hold(8'hFF, 8);
    hold(8'h0F, 12);
    check("simul_pout", pout, 8'h0F);
    hold(8'hFF, 12);

    // Reset mid-count on bit 2, then full latency again.
    hold(8'hFB, 4);
    tick(8'hFB, 1'b1, 1'b1);
    check("midreset_pout", pout, 8'hFF);
    hold(8'hFB, 5);
    check("midreset_still_high", pout, 8'hFF);
    hold(8'hFB, 6);
    check("midreset_accepted", pout, 8'hFB);

    // Random: slowly varying pins with occasional bounce, random CE/RES.
    p = pin;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 9) == 0) p[$urandom_range(0, W - 1)] ^= 1'b1;
      tick(p, ($urandom_range(0, 3) != 0), ($urandom_range(0, 599) == 0));
    end
    hold(p, 20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events actual=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/port_input_conditioner.md
Name: port_input_conditioner

Overview:
- Conditions raw, asynchronous board pins (buttons, switches, joystick lines) before they reach the RIOT port inputs.
- Each bit is synchronised into CLK, then debounced by its own counter.
- Drives a clean byte that ties straight to PAin/PBin.
- Also produces one-cycle rise/fall pulses and an any-change pulse for other logic (e.g. PA7-style edge interrupts).

Parameters:
- WIDTH, 8: number of conditioned bits.
- DB_CYCLES, 1000: number of qualifying mismatch samples needed to accept a new level. Legal values are 1 .. 2^CNT_W.
- CNT_W, 10: width of each per-bit debounce counter.
- RST_VAL, 8'hFF: value of Pout after reset (WIDTH bits; idle-high pull-ups).

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- RES  input  1  synchronous, active-high reset.
- CE  input  1  sample enable (prescaler tick); counters advance only when CE=1.
- Pin  input  WIDTH  raw asynchronous pin levels.
- Pout  output  WIDTH  debounced stable levels, fed to the RIOT PAin/PBin.
- Rise  output  WIDTH  one-cycle pulse per bit on an accepted 0->1 transition.
- Fall  output  WIDTH  one-cycle pulse per bit on an accepted 1->0 transition.
- Changed  output  1  OR of Rise|Fall, registered in the same cycle as them.

Behaviour:
- Reset (RES=1 at posedge), for all bits:
  - sync1 and sync2 <= RST_VAL.
  - Pout <= RST_VAL.
  - counters <= 0.
  - Rise, Fall and Changed <= 0.
  - Reset wins over every other event and is the same whether or not a debounce is in progress.
- Synchroniser: a two-flop chain per bit, Pin -> sync1 -> sync2. Only sync2 is used downstream.
- Per-bit rule on each posedge when RES=0, with mismatch = (sync2[i] != Pout[i]):
  - mismatch=0: cnt[i] <= 0 regardless of CE. This is the glitch-rejection case.
  - mismatch=1, CE=0: cnt[i] holds.
  - mismatch=1, CE=1, cnt[i] == DB_CYCLES-1: Pout[i] <= sync2[i], cnt[i] <= 0, and Rise[i] or Fall[i] <= 1 according to the new level.
  - mismatch=1, CE=1, otherwise: cnt[i] <= cnt[i]+1.
- Pulses:
  - Rise, Fall and Changed default to 0 on every edge that does not accept a transition, so each pulse lasts exactly one cycle.
  - Several bits may pulse in the same cycle.
  - Rise[i] and Fall[i] are never both 1.
- Latency with CE tied high: a Pin change that is stable before edge k appears on Pout after edge k+1+DB_CYCLES.
  - Two edges are spent in the synchroniser; the remaining DB_CYCLES are mismatch samples.
  - Example, DB_CYCLES=4, change before edge 1: sync2 changes at edge 2; Pout changes at edge 6.
- Counter arithmetic:
  - Unsigned.
  - The counter never exceeds DB_CYCLES-1, so there is no wrap-around.
  - The comparison uses the full CNT_W width.
- DB_CYCLES=1: a new level is accepted on the first CE edge after sync2 mismatches.
- Pin returning to the old level mid-count: the counter clears and Pout is unchanged. A bounce therefore restarts the full count.
- Bits are fully independent; there is no shared state between bits.
- All outputs are registered. There are no combinational paths from Pin or CE to any output.

Test Plan:
- Reset: after RES high for 1 cycle, Pout=8'hFF, Rise=Fall=0, Changed=0; hold Pin=8'hFF for 50 cycles and confirm no pulses occur.
- Clean press, DB_CYCLES=4, CE=1: Pin[0] goes 1->0 before edge 1.
  - Pout[0]=0 after edge 6.
  - Fall=8'h01 and Changed=1 for exactly the cycle after edge 6.
  - Pout[0] still 1 after edge 5.
- Bounce rejection, DB_CYCLES=4: Pin[3] toggles 1,0,1,0 every 2 cycles, then holds 0.
  - No pulse during toggling.
  - Pout[3]=0 exactly 2+4 edges after the last toggle.
  - Fall=8'h08 once.
- CE gating, DB_CYCLES=4: Pin[7] 0->1 with CE high only every 3rd cycle.
  - Pout[7] changes on the 4th CE-high edge after sync2 mismatches.
  - Rise=8'h80 for one cycle.
- Simultaneous bits: Pin 8'hFF->8'h0F in a single cycle gives Fall=8'hF0 in one cycle and Changed=1; Pout=8'h0F.
- Reset mid-count: assert RES when cnt[2]=2 with Pin[2] changed.
  - Pout[2] returns to the RST_VAL bit and the counter returns to 0.
  - After release, the full 2+DB_CYCLES latency applies again.
